// File: rtl/pipe_mac_pkg.sv
// Shared widths, result-slice helpers and the per-beat sideband carried down
// the pipe_mac pipeline.
package pipe_mac_pkg;

  localparam int GUARD_BITS = 4;
  localparam int SB_IDW_MAX = 16;
  localparam int SB_UDW_MAX = 8;

  function automatic int acc_w(input int dw);
    return 2 * dw + 2 * GUARD_BITS;
  endfunction

  // Q16.16 result window inside the guarded accumulator
  function automatic int res_hi(input int dw);
    return acc_w(dw) - GUARD_BITS - 1 - dw / 2;
  endfunction

  function automatic int res_lo(input int dw);
    return dw / 2 + GUARD_BITS;
  endfunction

  typedef struct packed {
    logic                  last;
    logic                  first;
    logic [SB_UDW_MAX-1:0] user;
    logic [SB_IDW_MAX-1:0] id;
  } beat_sb_t;

endpackage

// File: rtl/pipe_mac_mul.sv
// Stage 2 of pipe_mac: registered full-width signed multiplier that holds its
// product while the pipeline is stalled.
module pipe_mac_mul #(
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic signed [DW-1:0]   a,
  input  logic signed [DW-1:0]   b,
  output logic signed [2*DW-1:0] p
);

  // NOTE: registers are written with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      p <= '0;
    end else if (en) begin
      p <= a * b;
    end
  end

endmodule

// File: rtl/pipe_mac.sv
// Pipelined signed fixed-point MAC: accepts {weight, activation} beats over
// AXI-Stream and emits one truncated Q16.16 sum per TLAST-delimited group.
module pipe_mac
  import pipe_mac_pkg::*;
#(
  parameter int DW          = 32,
  parameter int IDW         = 8,
  parameter int UDW         = 1,
  parameter int FILTER_SIZE = 25
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [2*DW-1:0] saxis_tdata,
  input  logic            saxis_tvalid,
  output logic            saxis_tready,
  input  logic            saxis_tlast,
  input  logic [UDW-1:0]  saxis_tuser,
  input  logic [IDW-1:0]  saxis_tid,
  output logic [DW-1:0]   maxis_tdata,
  output logic            maxis_tvalid,
  input  logic            maxis_tready,
  output logic            maxis_tlast,
  output logic [IDW-1:0]  maxis_tid,
  output logic [UDW-1:0]  maxis_tuser
);

  localparam int ACC_W  = acc_w(DW);
  localparam int RES_HI = res_hi(DW);
  localparam int RES_LO = res_lo(DW);
  localparam int CNT_W  = $clog2(FILTER_SIZE + 1);

  logic stall;
  logic accept;

  assign stall        = maxis_tvalid & ~maxis_tready;
  assign saxis_tready = ~rstn & ~stall;
  assign accept       = saxis_tvalid & saxis_tready;

  // ---------------- stage 1: operand capture and group framing
  logic [CNT_W-1:0]     beat_cnt;
  logic                 first_q;
  beat_sb_t             in_sb;
  logic                 s1_valid;
  logic signed [DW-1:0] s1_w;
  logic signed [DW-1:0] s1_a;
  beat_sb_t             s1_sb;

  // NOTE: every field gets a default before the partial writes, so no latch is inferred.
  always_comb begin
    in_sb              = '0;
    in_sb.last         = saxis_tlast | (beat_cnt == CNT_W'(FILTER_SIZE - 1));
    in_sb.first        = first_q;
    in_sb.user[UDW-1:0] = saxis_tuser;
    in_sb.id[IDW-1:0]   = saxis_tid;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_valid <= 1'b0;
      s1_w     <= '0;
      s1_a     <= '0;
      s1_sb    <= '0;
      beat_cnt <= '0;
      first_q  <= 1'b1;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_w     <= saxis_tdata[2*DW-1:DW];
        s1_a     <= saxis_tdata[DW-1:0];
        s1_sb    <= in_sb;
        first_q  <= in_sb.last;
        beat_cnt <= in_sb.last ? '0 : beat_cnt + 1'b1;
      end
    end
  end

  // ---------------- stage 2: multiply
  logic signed [2*DW-1:0] s2_p;
  logic                   s2_valid;
  logic signed [DW-1:0]   s2_a;
  beat_sb_t               s2_sb;

  pipe_mac_mul #(.DW(DW)) u_mul (
    .clk  (clk),
    .rstn (rstn),
    .en   (~stall),
    .a    (s1_w),
    .b    (s1_a),
    .p    (s2_p)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      s2_valid <= 1'b0;
      s2_a     <= '0;
      s2_sb    <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      s2_a     <= s1_a;
      s2_sb    <= s1_sb;
    end
  end

  // ---------------- stage 3: accumulate in the guarded product domain
  logic [ACC_W-1:0]      term;
  logic [ACC_W-1:0]      bias;
  logic [ACC_W-1:0]      acc;
  logic                  s3_valid;
  beat_sb_t              s3_sb;
  logic [SB_UDW_MAX-1:0] grp_user;

  assign term = {{GUARD_BITS{s2_p[2*DW-1]}}, s2_p, {GUARD_BITS{1'b0}}};
  // bias is the activation moved so its binary point lines up with the product's
  assign bias = {{(GUARD_BITS + DW/2){s2_a[DW-1]}}, s2_a, {(DW/2 + GUARD_BITS){1'b0}}};

  always_ff @(posedge clk) begin
    if (rstn) begin
      acc      <= '0;
      s3_valid <= 1'b0;
      s3_sb    <= '0;
      grp_user <= '0;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      s3_sb    <= s2_sb;
      if (s2_valid) begin
        if (s2_sb.first) begin
          acc      <= (s2_sb.user[0] ? bias : '0) + term;
          grp_user <= s2_sb.user;
        end else begin
          acc <= acc + term;
        end
      end
    end
  end

  // ---------------- output register
  always_ff @(posedge clk) begin
    if (rstn) begin
      maxis_tvalid <= 1'b0;
      maxis_tdata  <= '0;
      maxis_tlast  <= 1'b0;
      maxis_tid    <= '0;
      maxis_tuser  <= '0;
    end else if (!stall) begin
      maxis_tvalid <= s3_valid & s3_sb.last;
      if (s3_valid && s3_sb.last) begin
        maxis_tdata <= acc[RES_HI:RES_LO];
        maxis_tlast <= 1'b1;
        maxis_tid   <= s3_sb.id[IDW-1:0];
        maxis_tuser <= grp_user[UDW-1:0];
      end
    end
  end

  // sideband bits that only exist because the shared struct is sized for the widest user
  logic sb_unused;
  assign sb_unused = ^{s3_sb.first, s3_sb.user, s3_sb.id, grp_user};

endmodule

// File: tb/tb_pipe_mac.sv
// Self-checking bench for pipe_mac: directed fixed-point cases plus randomized
// groups checked against an arithmetic model of the group sums.
module tb_pipe_mac;

  localparam int DW          = 32;
  localparam int IDW         = 8;
  localparam int UDW         = 1;
  localparam int FILTER_SIZE = 25;

  logic            clk = 1'b0;
  logic            rstn = 1'b1;
  logic [2*DW-1:0] saxis_tdata = '0;
  logic            saxis_tvalid = 1'b0;
  logic            saxis_tready;
  logic            saxis_tlast = 1'b0;
  logic [UDW-1:0]  saxis_tuser = '0;
  logic [IDW-1:0]  saxis_tid = '0;
  logic [DW-1:0]   maxis_tdata;
  logic            maxis_tvalid;
  logic            maxis_tready = 1'b1;
  logic            maxis_tlast;
  logic [IDW-1:0]  maxis_tid;
  logic [UDW-1:0]  maxis_tuser;

  pipe_mac #(.DW(DW), .IDW(IDW), .UDW(UDW), .FILTER_SIZE(FILTER_SIZE)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .saxis_tdata  (saxis_tdata),
    .saxis_tvalid (saxis_tvalid),
    .saxis_tready (saxis_tready),
    .saxis_tlast  (saxis_tlast),
    .saxis_tuser  (saxis_tuser),
    .saxis_tid    (saxis_tid),
    .maxis_tdata  (maxis_tdata),
    .maxis_tvalid (maxis_tvalid),
    .maxis_tready (maxis_tready),
    .maxis_tlast  (maxis_tlast),
    .maxis_tid    (maxis_tid),
    .maxis_tuser  (maxis_tuser)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model: group sums as plain wide integers
  typedef struct {
    logic [31:0] data;
    logic [7:0]  id;
    logic        user;
    int          acc_edge;
  } exp_t;

  exp_t               exp_q[$];
  logic signed [127:0] m_total;
  logic               m_first = 1'b1;
  logic               m_user;
  int                 m_cnt;

  task automatic model_accept(input logic [31:0] w, input logic [31:0] a, input logic last,
                              input logic user, input logic [7:0] id, input int edge_n);
    logic signed [127:0] tw;
    logic signed [127:0] ta;
    exp_t e;
    tw = $signed(w);
    ta = $signed(a);
    if (m_first) begin
      m_total = user ? (ta <<< 16) : '0;
      m_user  = user;
      m_cnt   = 0;
    end
    m_total = m_total + tw * ta;
    m_cnt++;
    m_first = 1'b0;
    if (last || m_cnt == FILTER_SIZE) begin
      e.data     = m_total[47:16];
      e.id       = id;
      e.user     = m_user;
      e.acc_edge = edge_n;
      exp_q.push_back(e);
      m_first = 1'b1;
    end
  endtask

  // ---------------- output monitor
  logic        head_seen = 1'b0;
  exp_t        mon_e;
  int          n_out = 0;
  logic [31:0] last_data;
  logic [7:0]  last_id;
  logic        last_user;

  always @(negedge clk) begin
    if (!rstn) begin
      if (maxis_tvalid && !head_seen) begin
        head_seen = 1'b1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_result observed %h expected none", maxis_tdata);
        end else begin
          chk("latency", 64'(cyc - exp_q[0].acc_edge), 64'd3);
        end
      end
      if (maxis_tvalid && maxis_tready) begin
        head_seen = 1'b0;
        n_out++;
        last_data = maxis_tdata;
        last_id   = maxis_tid;
        last_user = maxis_tuser[0];
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("res_data", maxis_tdata, mon_e.data);
          chk("res_id", maxis_tid, mon_e.id);
          chk("res_user", maxis_tuser[0], mon_e.user);
          chk("res_last", maxis_tlast, 1'b1);
        end
      end
    end else begin
      head_seen = 1'b0;
    end
  end

  // ---------------- stimulus helpers (called at a negedge, return at a negedge)
  task automatic send(input logic [31:0] w, input logic [31:0] a, input logic last,
                      input logic user, input logic [7:0] id);
    int n = 0;
    saxis_tdata  = {w, a};
    saxis_tlast  = last;
    saxis_tuser  = user;
    saxis_tid    = id;
    saxis_tvalid = 1'b1;
    while (!saxis_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!saxis_tready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout observed tready=0 expected tready=1 id %h", id);
    end else begin
      model_accept(w, a, last, user, id, cyc + 1);
    end
    @(negedge clk);
    saxis_tvalid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  localparam logic [31:0] W_1P125 = 32'h0001_2000;
  localparam logic [31:0] A_2P25  = 32'h0002_4000;

  initial begin
    int base;
    int n;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_tready", saxis_tready, 1'b0);
    chk("rst_tvalid", maxis_tvalid, 1'b0);
    chk("rst_tdata", maxis_tdata, 32'h0);
    chk("rst_tlast", maxis_tlast, 1'b0);
    rstn = 1'b0;
    #1;
    chk("rst_release_tready", saxis_tready, 1'b1);
    @(negedge clk);

    // single beat 1.125 * 2.25
    base = n_out;
    send(W_1P125, A_2P25, 1'b1, 1'b0, 8'h07);
    drain();
    chk("single_count", 64'(n_out - base), 64'd1);
    chk("single_data", last_data, 32'h0002_8800);
    chk("single_id", last_id, 8'h07);

    // ten beats, one result
    base = n_out;
    for (int i = 0; i < 10; i++) send(W_1P125, A_2P25, i == 9, 1'b0, 8'(i));
    drain();
    chk("ten_count", 64'(n_out - base), 64'd1);
    chk("ten_data", last_data, 32'h0019_5000);
    chk("ten_id", last_id, 8'h09);

    // ten beats with bias init on the first beat
    for (int i = 0; i < 10; i++) send(W_1P125, A_2P25, i == 9, i == 0, 8'(i));
    drain();
    chk("bias_data", last_data, 32'h001B_9000);
    chk("bias_user", last_user, 1'b1);

    // signed: -1.0 * 2.0
    send(32'hFFFF_0000, 32'h0002_0000, 1'b1, 1'b0, 8'h11);
    drain();
    chk("signed_data", last_data, 32'hFFFE_0000);

    // backpressure on the result
    @(posedge clk);
    #1 maxis_tready = 1'b0;
    @(negedge clk);
    base = n_out;
    send(W_1P125, A_2P25, 1'b1, 1'b0, 8'h21);
    n = 0;
    while (!maxis_tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid", maxis_tvalid, 1'b1);
    repeat (3) @(negedge clk);
    chk("bp_hold_valid", maxis_tvalid, 1'b1);
    chk("bp_hold_data", maxis_tdata, 32'h0002_8800);
    chk("bp_hold_id", maxis_tid, 8'h21);
    chk("bp_tready", saxis_tready, 1'b0);
    @(posedge clk);
    #1 maxis_tready = 1'b1;
    @(negedge clk);
    drain();
    chk("bp_count", 64'(n_out - base), 64'd1);
    send(32'hFFFF_0000, 32'h0002_0000, 1'b1, 1'b0, 8'h22);
    drain();
    chk("bp_next_data", last_data, 32'hFFFE_0000);

    // reset in the middle of a group
    for (int i = 0; i < 5; i++) send(W_1P125, A_2P25, 1'b0, i == 0, 8'(i));
    rstn = 1'b1;
    #1;
    chk("midrst_tready", saxis_tready, 1'b0);
    repeat (2) @(negedge clk);
    chk("midrst_tvalid", maxis_tvalid, 1'b0);
    m_first = 1'b1;
    exp_q.delete();
    rstn = 1'b0;
    @(negedge clk);
    base = n_out;
    send(W_1P125, A_2P25, 1'b1, 1'b0, 8'h33);
    drain();
    chk("midrst_count", 64'(n_out - base), 64'd1);
    chk("midrst_data", last_data, 32'h0002_8800);

    // forced close at FILTER_SIZE beats, remainder closes on TLAST
    base = n_out;
    for (int i = 0; i < FILTER_SIZE + 2; i++)
      send(32'h0001_0000, 32'h0001_0000, i == FILTER_SIZE + 1, 1'b0, 8'(i));
    drain();
    chk("forced_count", 64'(n_out - base), 64'd2);
    chk("forced_tail_data", last_data, 32'h0002_0000);

    // randomized groups with input bubbles
    for (int g = 0; g < 12; g++) begin
      int len;
      len = int'($urandom_range(1, 6));
      for (int i = 0; i < len; i++) begin
        send($urandom, $urandom, i == len - 1, 1'($urandom), 8'($urandom));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_mac.md
Name: pipe_mac

Overview:
- Pipelined signed fixed-point multiply-accumulate engine with AXI-Stream in/out.
- Each input beat carries a {weight, activation} pair (Q16.16 for DW=32).
- Products are summed over a group of beats terminated by TLAST.
- One rounded-down (truncated) Q16.16 result beat is emitted per group; the block sits between an operand-fetch stream and a result-writeback stream in the conv/FC datapath.

Parameters:
- DW, 32, operand and result width; fixed point has DW/2 fraction bits.
- IDW, 8, TID width.
- UDW, 1, TUSER width; bit 0 = "bias-init" flag.
- FILTER_SIZE, 25, maximum beats per group; sizes the beat counter.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous reset, active-high (rstn=1 resets on the clk rising edge).
- saxis_tdata  in  2*DW  [2DW-1:DW]=weight, [DW-1:0]=activation, both signed.
- saxis_tvalid  in  1  input beat valid.
- saxis_tready  out  1  input beat accepted when tvalid&tready.
- saxis_tlast  in  1  last beat of group.
- saxis_tuser  in  UDW  bit0 on first beat of group = initialise accumulator with activation as bias.
- saxis_tid  in  IDW  beat id.
- maxis_tdata  out  DW  Q16.16 result.
- maxis_tvalid  out  1  result valid.
- maxis_tready  in  1  downstream ready.
- maxis_tlast  out  1  always 1 with a result beat.
- maxis_tid  out  IDW  TID of the group's TLAST beat.
- maxis_tuser  out  UDW  TUSER of the group's first beat.

Behaviour:
- Reset (rstn=1):
  - All pipeline valids, accumulator, beat counter, maxis_tvalid/tdata/tlast/tid/tuser cleared to 0.
  - saxis_tready=0 during reset; "first beat" flag set.
  - Reset mid-group discards the partial sum and any pending result.
- Stall:
  - stall = maxis_tvalid & ~maxis_tready.
  - saxis_tready = ~rstn & ~stall.
  - A stall freezes every stage; output holds data/tid/tuser/tlast stable until accepted.
- Stage 1: register the accepted operands plus tlast, tuser, tid and the first flag.
- Stage 2: full signed DW x DW multiply -> 2*DW product P.
- Stage 3: accumulate into ACC, width ACC_W = 2*DW+8.
  - Term = {4 sign bits of P, P, 4'b0}.
  - First beat with tuser[0]=1: ACC = BIAS + Term, where BIAS = activation sign-extended by 4+DW/2 bits, then activation, then DW/2+4 zero bits (activation scaled into the product domain).
  - First beat with tuser[0]=0: ACC = Term.
  - Other beats: ACC += Term.
  - Overflow wraps modulo 2^ACC_W.
- Result: maxis_tdata = ACC[ACC_W-5-DW/2 : DW/2+4], i.e. [51:20] for DW=32. Truncation, no rounding, no saturation.
- Latency: result valid exactly 3 cycles after the TLAST beat is accepted, with no stall.
- Throughput: one beat per cycle.
- Back-to-back groups: the next beat after TLAST is a first beat; group N+1 may enter while result N is pending.
- Forced group close: if the beat counter reaches FILTER_SIZE without TLAST, that beat is treated as last; its TID is forwarded and maxis_tlast=1.
- Output register: maxis_tvalid clears on tvalid&tready unless a new result loads in the same cycle, in which case it stays 1 with the new data.
- saxis_tvalid=0 inserts bubbles; the accumulator is unaffected.

Decomposition:
- Package pipe_mac_pkg holds:
  - GUARD_BITS=4.
  - ACC_W function of DW.
  - Output slice index functions.
  - A beat sideband struct {last, first, user, id}.
- One sub-module, pipe_mac_mul: registered signed DW x DW multiplier, stage 2, with enable for stall.

Test Plan:
- Single beat, weight 0x00012000 (1.125), activation 0x00024000 (2.25), tuser=0, tlast=1, tid=0x07 -> one beat 0x00028800, tlast=1, tid=0x07, 3 cycles after accept.
- Same pair for 10 beats, tlast on beat 10 (tid 9) -> 0x00028800*10 = 0x00195000, tid=0x09; single output beat only.
- Same 10 beats with tuser=1 on beat 0 -> 0x00195000+0x00024000 = 0x001B9000.
- Signed: weight 0xFFFF0000 (-1.0), activation 0x00020000 (2.0), single last beat -> 0xFFFE0000.
- Backpressure: maxis_tready=0 when result appears -> tvalid/data held, saxis_tready=0 next cycle; raise tready -> accepted once, input resumes, next group correct.
- Reset after 5 beats of a group, then a fresh 1-beat group (1.125*2.25) -> 0x00028800, no residue.
- Random weights/activations and random tvalid gaps -> result equals the signed reference model using the slice above.
